inst_queue_reg: RTL
===================

# inst_queue_reg

Parametrised instruction register with a prefetch queue, sitting between instruction memory and the control unit. It accepts instruction words over a valid/ready handshake into a DEPTH-entry FIFO. On `c_next` it loads the head entry into the current instruction register (IR). From the IR it decodes the opcode and register address, and it drives a zero- or sign-extended immediate onto the shared tri-state data bus. A `flush` input discards all queued and current instructions on branch/jump.

## Interface
- INST_W, 16, instruction word width
- BUS_W, 8, shared data bus width
- OPC_W, 4, opcode field width; field is IR[INST_W-1 -: OPC_W]
- RADDR_W, 4, register-address field width; field is IR[INST_W-OPC_W-1 -: RADDR_W]
- IMM_W, 8, immediate field width; field is IR[IMM_W-1:0]; legal range 1..BUS_W
- DEPTH, 4, queue entries; power of two, >= 2

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- inst  in  INST_W  instruction word from fetch
- in_valid  in  1  `inst` valid
- in_ready  out  1  queue can accept a word; equals (count != DEPTH)
- c_next  in  1  advance: load queue head into IR
- flush  in  1  discard queue and IR contents
- c_imm  in  1  drive zero-extended immediate on bus
- c_imm_s  in  1  drive sign-extended immediate on bus
- cur_valid  out  1  IR holds a real instruction
- c_opcode  out  OPC_W  opcode field of IR
- regaddr  out  RADDR_W  register-address field of IR, to datamem
- count  out  $clog2(DEPTH+1)  queue occupancy
- bus  out  BUS_W  immediate when enabled, else high-Z

## Operation
- Queue
  - Circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits. Pointers wrap mod DEPTH.
  - Occupancy is tracked by `count`, ranging 0..DEPTH.
- Push
  - A push occurs when in_valid && in_ready at the rising edge.
  - The word is written at wr_ptr, wr_ptr increments, and count increments.
- Pop (c_next, no flush)
  - If count != 0: IR <= head, cur_valid <= 1, rd_ptr increments, count decrements.
  - If count == 0: IR <= 0 and cur_valid <= 0 (bubble).
- Simultaneous push and pop
  - count is unchanged.
  - There is no bypass. With an empty queue, the pushed word is stored and the IR takes a bubble.
- Full queue: in_ready = 0. A pop in the same cycle does not raise in_ready until the next cycle.
- flush has highest priority and overrides push and c_next in the same cycle.
  - Effects: count <= 0, pointers <= 0, IR <= 0, cur_valid <= 0.
  - An in_valid word presented during flush is dropped.
- Without c_next or flush, the IR holds its value.
- Bus drive, combinational from the IR:
  - The bus is driven only when cur_valid && (c_imm || c_imm_s); otherwise all BUS_W bits are Z.
  - c_imm_s set: bus = sign-extension of IR[IMM_W-1:0] to BUS_W. Sign extension wins if both enables are set.
  - else c_imm set: bus = zero-extension of the immediate.
  - IMM_W == BUS_W: both modes drive the field unchanged.
- c_opcode and regaddr are always the IR fields (0 while cur_valid = 0 after reset/flush/bubble).

## Timing
- reset low, asynchronous, effective immediately:
  - count = 0, pointers = 0, IR = 0, cur_valid = 0
  - in_ready = 1, c_opcode = 0, regaddr = 0, bus = Z
- While reset is low, all inputs are ignored. Release is synchronous to the next rising edge.
- A mid-operation reset discards all queued words exactly like flush.
- Push latency: a word accepted at edge k is reflected in count after edge k.
- Fastest path from empty: accepted at edge k; c_next at edge k+1 gives cur_valid = 1 and decoded fields after edge k+1.
- Throughput: one push and one pop per cycle, sustained while 0 < count < DEPTH.
- Bus enable to bus drive is purely combinational (same cycle), with no registered stage.

## Test plan
- Reset/idle:
  - Stimulus: hold reset low with in_valid = 1 and c_imm = 1.
  - Required: count = 0, in_ready = 1, cur_valid = 0, bus = 8'hzz.
  - After release with no c_next: count increments per accepted word.
- Fill/full/wrap:
  - Stimulus: push 16'h1A05, 16'h2B06, 16'h3C07, 16'h4D08; in_ready stays 0 with in_valid held. Then pop 4 times while pushing 16'h5E09 after the first pop frees a slot.
  - Required: c_opcode sequence 1,2,3,4 then 5, regaddr A,B,C,D,E, and count never exceeds 4.
- Immediate modes (IMM_W = 6 override):
  - IR = 16'h7035 (imm 6'h35): c_imm gives bus 8'h35; c_imm_s gives 8'hF5; both set gives 8'hF5; neither gives Z.
  - Default IMM_W = 8, IR = 16'h70C3: c_imm_s gives 8'hC3.
- Empty pop and push together:
  - Stimulus: empty queue; in_valid with 16'h9100 and c_next in the same cycle.
  - Required: cur_valid = 0, count = 1. Next c_next gives c_opcode = 9, regaddr = 1, cur_valid = 1.
- Flush priority:
  - Stimulus: count = 3 and cur_valid = 1; assert flush with in_valid and c_next in the same cycle.
  - Required: count = 0, cur_valid = 0, c_opcode = 0, bus = Z. Next c_next yields a bubble.
- Async reset mid-stream:
  - Stimulus: drop reset between edges while count = 2.
  - Required: all outputs at reset values before the next edge, and no stale words after release.

Source files
------------

// File: rtl/inst_queue_reg.sv
// Instruction register with a DEPTH-entry prefetch queue.
// Accepts fetched words over valid/ready, loads the queue head into the IR
// on c_next, decodes opcode/register fields and drives an extended immediate
// onto the shared tri-state data bus.
module inst_queue_reg #(
  parameter int unsigned INST_W  = 16,
  parameter int unsigned BUS_W   = 8,
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned IMM_W   = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INST_W-1:0]            inst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         c_next,
  input  logic                         flush,
  input  logic                         c_imm,
  input  logic                         c_imm_s,
  output logic                         cur_valid,
  output logic [OPC_W-1:0]             c_opcode,
  output logic [RADDR_W-1:0]           regaddr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [BUS_W-1:0]             bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [INST_W-1:0] ir;
  logic              push;
  logic              pop;
  logic [BUS_W-1:0]  bus_val;
  logic              bus_en;

  // Queue has room whenever it is not holding DEPTH words
  assign in_ready = (count != CNT_W'(DEPTH));

  // Handshake qualifiers; flush drops both the incoming word and the advance
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (!flush) begin
      push = in_valid && in_ready;
      pop  = c_next && (count != CNT_W'(0));
    end
  end

  // Storage array; stale entries are harmless because pointers gate reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= inst;
    end
  end

  // Pointers, occupancy and the current instruction register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ir        <= '0;
      cur_valid <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ir        <= '0;
      cur_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Advance with an empty queue inserts a bubble; no bypass of the pushed word
      if (c_next) begin
        if (pop) begin
          ir        <= mem[rd_ptr];
          cur_valid <= 1'b1;
        end else begin
          ir        <= '0;
          cur_valid <= 1'b0;
        end
      end
    end
  end

  // Instruction field decode straight from the IR
  assign c_opcode = ir[INST_W-1 -: OPC_W];
  assign regaddr  = ir[INST_W-OPC_W-1 -: RADDR_W];

  // Immediate extension; upper bits follow the sign only in signed mode
  for (genvar i = 0; i < int'(BUS_W); i++) begin : g_ext
    if (i < int'(IMM_W)) begin : g_field
      assign bus_val[i] = ir[i];
    end else begin : g_fill
      assign bus_val[i] = c_imm_s & ir[IMM_W-1];
    end
  end

  // Tri-state bus driver, enabled combinationally
  assign bus_en = cur_valid && (c_imm || c_imm_s);
  assign bus    = bus_en ? bus_val : {BUS_W{1'bz}};

endmodule
